neuron_acc_ctrl: RTL and testbench

NEURON_ACC_CTRL -- requirements
Module: neuron_acc_ctrl

---
 rtl/neuron_acc_ctrl.sv | 135 +++++++++++++
 tb/tb_neuron_acc_ctrl.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/neuron_acc_ctrl.sv
// ============================================================================
//  Module   : neuron_acc_ctrl (with local alu)
//  Brief    : Binary-neuron XNOR-popcount accumulator controller.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu #(
    parameter int alu_width = 12
) (
    input  logic                 alu_in_a_lsb,
    input  logic [alu_width-1:0] alu_in_b,
    input  logic                 alu_op,
    output logic [alu_width-1:0] alu_out
);
    logic [alu_width-1:0] a_ext;

    assign a_ext   = {{(alu_width-1){1'b0}}, alu_in_a_lsb};
    assign alu_out = alu_op ? (alu_in_b - a_ext) : (alu_in_b + a_ext);
endmodule

module neuron_acc_ctrl #(
    parameter int ALU_W = 12,
    parameter int N_IN  = 784,
    parameter int AW    = 10
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic signed [ALU_W-1:0] bias_in,
    output logic                    rd_en,
    output logic [AW-1:0]           rd_addr,
    input  logic                    x_bit,
    input  logic                    w_bit,
    output logic                    busy,
    output logic                    done,
    output logic signed [ALU_W-1:0] acc_out,
    output logic                    act_out
);
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    localparam logic [AW-1:0] LAST_ADDR = AW'(N_IN - 1);

    state_t                  state_q;
    logic signed [ALU_W-1:0] acc_q;
    logic signed [ALU_W-1:0] acc_d;
    logic [AW-1:0]           rd_addr_q;
    logic                    rd_en_q;
    logic                    vld_q;
    logic                    busy_q;
    logic                    done_q;
    logic signed [ALU_W-1:0] acc_out_q;
    logic                    act_out_q;
    logic [ALU_W-1:0]        alu_res;

    // Matching bits add one, mismatching bits subtract one.
    alu #(.alu_width(ALU_W)) u_alu (
        .alu_in_a_lsb (1'b1),
        .alu_in_b     (acc_q),
        .alu_op       (x_bit ^ w_bit),
        .alu_out      (alu_res)
    );

    always_comb begin
        acc_d = acc_q;
        if (state_q == S_IDLE && start) begin
            acc_d = bias_in;
        end else if (vld_q) begin
            acc_d = alu_res;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            acc_q     <= '0;
            rd_addr_q <= '0;
            rd_en_q   <= 1'b0;
            vld_q     <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            acc_out_q <= '0;
            act_out_q <= 1'b1;
        end else begin
            acc_q  <= acc_d;
            vld_q  <= rd_en_q;
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        state_q   <= S_FETCH;
                        rd_addr_q <= '0;
                        rd_en_q   <= 1'b1;
                        busy_q    <= 1'b1;
                    end
                end
                S_FETCH: begin
                    if (rd_addr_q == LAST_ADDR) begin
                        state_q <= S_DRAIN;
                        rd_en_q <= 1'b0;
                    end else begin
                        rd_addr_q <= rd_addr_q + 1'b1;
                    end
                end
                S_DRAIN: begin
                    state_q <= S_DONE;
                end
                S_DONE: begin
                    acc_out_q <= acc_q;
                    act_out_q <= ~acc_q[ALU_W-1];
                    done_q    <= 1'b1;
                    busy_q    <= 1'b0;
                    state_q   <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign rd_en   = rd_en_q;
    assign rd_addr = rd_addr_q;
    assign busy    = busy_q;
    assign done    = done_q;
    assign acc_out = acc_out_q;
    assign act_out = act_out_q;
endmodule

`default_nettype wire

// File: tb/tb_neuron_acc_ctrl.sv
// ============================================================================
//  Module   : tb_neuron_acc_ctrl
//  Brief    : Three neuron_acc_ctrl instances (N_IN = 4, 784, 1) checked
//             every cycle against a timeline model plus literal expectations.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_neuron_acc_ctrl;
    localparam int ND = 3;

    function automatic int ni(input int d);
        case (d)
            0:       return 4;
            1:       return 784;
            default: return 1;
        endcase
    endfunction

    logic                clk = 1'b0;
    logic                rst_n = 1'b1;
    logic                start = 1'b0;
    logic signed [11:0]  bias_in = '0;

    logic                rd_en   [ND];
    logic [9:0]          rd_addr [ND];
    logic                x_bit   [ND];
    logic                w_bit   [ND];
    logic                busy    [ND];
    logic                done    [ND];
    logic signed [11:0]  acc_out [ND];
    logic                act_out [ND];

    logic                xm [ND][784];
    logic                wm [ND][784];

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    for (genvar g = 0; g < ND; g++) begin : g_dut
        neuron_acc_ctrl #(.ALU_W(12), .N_IN(ni(g)), .AW(10)) u_dut (
            .clk     (clk),
            .rst_n   (rst_n),
            .start   (start),
            .bias_in (bias_in),
            .rd_en   (rd_en[g]),
            .rd_addr (rd_addr[g]),
            .x_bit   (x_bit[g]),
            .w_bit   (w_bit[g]),
            .busy    (busy[g]),
            .done    (done[g]),
            .acc_out (acc_out[g]),
            .act_out (act_out[g])
        );
    end

    // Bit memories: registered read, junk on the bus when not reading.
    always @(posedge clk) begin
        for (int d = 0; d < ND; d++) begin
            if (rd_en[d]) begin
                x_bit[d] <= xm[d][rd_addr[d]];
                w_bit[d] <= wm[d][rd_addr[d]];
            end else begin
                x_bit[d] <= 1'($urandom);
                w_bit[d] <= 1'($urandom);
            end
        end
    end

    task automatic chk(input string nm, input int d, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s dut%0d @cyc %0d: got %0d expected %0d", nm, d, cyc, got, exp);
        end
    endtask

    // Timeline model: mc = cycles since the accepting edge, -1 when idle.
    int                 mc    [ND];
    int                 maddr [ND];
    logic signed [11:0] macc  [ND];
    logic signed [11:0] mfin  [ND];

    function automatic logic m_idle(input int d);
        return (mc[d] == -1) || (mc[d] == ni(d) + 2);
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int d = 0; d < ND; d++) begin
                mc[d] = -1; maddr[d] = 0; macc[d] = '0; mfin[d] = '0;
            end
        end else begin
            for (int d = 0; d < ND; d++) begin
                if (m_idle(d)) begin
                    if (start) begin
                        int s;
                        s = bias_in;
                        for (int i = 0; i < ni(d); i++)
                            s += (xm[d][i] == wm[d][i]) ? 1 : -1;
                        mfin[d] = s[11:0];
                        mc[d] = 0;
                    end else begin
                        mc[d] = -1;
                    end
                end else begin
                    mc[d]++;
                end
                if (mc[d] >= 0 && mc[d] < ni(d)) maddr[d] = mc[d];
                if (mc[d] == ni(d) + 2) macc[d] = mfin[d];
            end
        end
    end

    always @(negedge clk) begin
        for (int d = 0; d < ND; d++) begin
            chk("busy",    d, int'(busy[d]),    int'(mc[d] >= 0 && mc[d] <= ni(d) + 1));
            chk("rd_en",   d, int'(rd_en[d]),   int'(mc[d] >= 0 && mc[d] < ni(d)));
            chk("rd_addr", d, int'(rd_addr[d]), maddr[d]);
            chk("done",    d, int'(done[d]),    int'(mc[d] == ni(d) + 2));
            chk("acc_out", d, int'(acc_out[d]), int'(macc[d]));
            chk("act_out", d, int'(act_out[d]), int'(!macc[d][11]));
        end
    end

    task automatic wait_done(input int d, input int maxc, output int at);
        at = -1;
        for (int i = 0; i < maxc; i++) begin
            @(negedge clk);
            if (done[d]) begin
                at = cyc;
                break;
            end
        end
        if (at < 0) chk("done_timeout", d, 0, 1);
    endtask

    task automatic run4(input logic signed [11:0] b, input logic [3:0] xv, input logic [3:0] wv,
                        input int ea, input int eact);
        int t, c, c2;
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            xm[0][i] = xv[i];
            wm[0][i] = wv[i];
        end
        xm[2][0] = xv[0];
        wm[2][0] = wv[0];
        bias_in = b;
        start   = 1'b1;
        t       = cyc + 1;
        @(negedge clk);
        start = 1'b0;
        wait_done(2, 10, c2);
        chk("lat_n1", 2, c2, t + 3);
        wait_done(0, 20, c);
        chk("lat_n4", 0, c, t + 6);
        chk("acc_n4", 0, int'(acc_out[0]), ea);
        chk("act_n4", 0, int'(act_out[0]), eact);
    endtask

    initial begin
        int t, c1, c2, nrd, ndn, r;
        for (int d = 0; d < ND; d++)
            for (int i = 0; i < 784; i++) begin
                xm[d][i] = 1'b0;
                wm[d][i] = 1'b0;
            end
        #1 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        for (int d = 0; d < ND; d++) begin
            chk("rst_busy", d, int'(busy[d]), 0);
            chk("rst_rden", d, int'(rd_en[d]), 0);
            chk("rst_addr", d, int'(rd_addr[d]), 0);
            chk("rst_done", d, int'(done[d]), 0);
            chk("rst_acc",  d, int'(acc_out[d]), 0);
            chk("rst_act",  d, int'(act_out[d]), 1);
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Long neuron, all matches, start held for two evaluations.
        for (int i = 0; i < 784; i++) begin
            xm[1][i] = 1'b1;
            wm[1][i] = 1'b1;
        end
        bias_in = '0;
        start   = 1'b1;
        t       = cyc + 1;
        wait_done(1, 800, c1);
        chk("lat_784", 1, c1, t + 786);
        chk("acc_784", 1, int'(acc_out[1]), 784);
        chk("act_784", 1, int'(act_out[1]), 1);
        wait_done(1, 800, c2);
        chk("lat_784_b2b", 1, c2, t + 786 + 787);
        chk("acc_784_b2b", 1, int'(acc_out[1]), 784);
        start = 1'b0;
        repeat (12) @(negedge clk);

        run4(12'sd0,  4'b1010, 4'b1010, 4, 1);
        run4(12'sd2,  4'b1111, 4'b0000, -2, 0);
        run4(-12'sd2, 4'b1100, 4'b1010, -2, 0);
        run4(12'sd0,  4'b1100, 4'b1010, 0, 1);

        // Start held through the whole evaluation must not relaunch it.
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            xm[0][i] = 1'b1;
            wm[0][i] = 1'b1;
        end
        bias_in = 12'sd3;
        start   = 1'b1;
        nrd = 0; ndn = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (i == 5) start = 1'b0;
            if (rd_en[0]) nrd++;
            if (done[0])  ndn++;
        end
        chk("hold_rden_cnt", 0, nrd, 4);
        chk("hold_done_cnt", 0, ndn, 1);
        chk("hold_acc", 0, int'(acc_out[0]), 7);

        // Reset three cycles into an evaluation aborts it.
        @(negedge clk);
        bias_in = 12'sd0;
        start   = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("abort_busy", 0, int'(busy[0]), 0);
        chk("abort_rden", 0, int'(rd_en[0]), 0);
        chk("abort_addr", 0, int'(rd_addr[0]), 0);
        chk("abort_acc",  0, int'(acc_out[0]), 0);
        chk("abort_act",  0, int'(act_out[0]), 1);
        @(negedge clk);
        rst_n = 1'b1;
        ndn = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (done[0]) ndn++;
        end
        chk("abort_no_done", 0, ndn, 0);
        run4(12'sd1, 4'b1111, 4'b1111, 5, 1);

        // Randomized traffic with occasional asynchronous resets.
        for (int k = 0; k < 700; k++) begin
            @(negedge clk);
            start = ($urandom_range(0, 3) == 0);
            r = $urandom_range(0, 1800);
            bias_in = 12'(r - 900);
            for (int d = 0; d < ND; d++) begin
                if (m_idle(d) && $urandom_range(0, 1) == 1) begin
                    for (int i = 0; i < ni(d); i++) begin
                        xm[d][i] = 1'($urandom);
                        wm[d][i] = 1'($urandom);
                    end
                end
            end
            if ($urandom_range(0, 249) == 0) begin
                #2 rst_n = 1'b0;
                #2 rst_n = 1'b1;
            end
        end
        start = 1'b0;
        repeat (10) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end
endmodule

`default_nettype wire
